axil_modport: RTL and testbench

AXI4-Lite slave register file implementing the DUT side of the `axil_if` bus: the `dut` modport, which the UVM master driver and monitor exercise. The block holds 16 32-bit read/write registers with byte-strobe writes. Unmapped addresses return error responses. It sits directly under the testbench top and is the only bus slave.

---
 rtl/axil_pkg.sv | 31 +++
 rtl/axil_regfile.sv | 32 +++
 rtl/axil_modport.sv | 144 ++++++++++++++
 tb/tb_axil_modport.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types: response codes, FSM state encodings and address decode.
// Pure definitions; no timing or backpressure of its own.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  typedef struct packed {
    logic             mapped;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Word index comes from addr[5:2]; the byte offset bits are ignored.
  function automatic dec_t decode(input logic [31:0] addr, input int num_regs);
    dec_t d;
    d.mapped = (addr < (32'(num_regs) * 32'd4));
    d.idx    = addr[IDX_W+1:2];
    return d;
  endfunction

endpackage

// File: rtl/axil_regfile.sv
// Word register array with a byte-strobed write port and a combinational read port.
// Writes land on the clock edge; reads see the pre-edge contents.
module axil_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        widx_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [IDX_W-1:0]        ridx_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb_i[b]) regs_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = regs_q[ridx_i];

endmodule

// File: rtl/axil_modport.sv
// AXI4-Lite slave over 16 x 32-bit registers; write commits 1 cycle after the later of AW/W,
// read data 1 cycle after AR. One outstanding transaction per path; B/R held until bready/rready.
module axil_modport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = axil_pkg::NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);
  import axil_pkg::*;

  logic                    live_q;
  wr_state_e               wst_q, wst_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  resp_e                   bresp_q, bresp_d;
  rd_state_e               rdst_q, rdst_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  resp_e                   rresp_q, rresp_d;
  logic                    aw_hs, w_hs, ar_hs, reg_we;
  dec_t                    wdec, rdec;
  logic [DATA_WIDTH-1:0]   rf_rdata;

  // live_q keeps all readies low until the first edge after reset release.
  assign awready = live_q & ((wst_q == WR_IDLE) | (wst_q == WR_HAVE_W));
  assign wready  = live_q & ((wst_q == WR_IDLE) | (wst_q == WR_HAVE_AW));
  assign arready = live_q & (rdst_q == RD_IDLE);
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign wdec    = decode(32'(awaddr_q), NUM_REGS);
  assign rdec    = decode(32'(araddr), NUM_REGS);
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign rvalid  = (rdst_q == RD_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  axil_regfile #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_regfile (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (reg_we),
    .widx_i (wdec.idx),
    .wdata_i(wdata_q),
    .wstrb_i(wstrb_q),
    .ridx_i (rdec.idx),
    .rdata_o(rf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q   <= 1'b0;
      wst_q    <= WR_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rdst_q   <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      live_q   <= 1'b1;
      wst_q    <= wst_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rdst_q   <= rdst_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  always_comb begin
    wst_d    = wst_q;
    awaddr_d = aw_hs ? awaddr : awaddr_q;
    wdata_d  = w_hs ? wdata : wdata_q;
    wstrb_d  = w_hs ? wstrb : wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    reg_we   = 1'b0;
    case (wst_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wst_d = WR_RESP;
        else if (aw_hs)    wst_d = WR_HAVE_AW;
        else if (w_hs)     wst_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)  wst_d = WR_RESP;
      WR_HAVE_W:  if (aw_hs) wst_d = WR_RESP;
      WR_RESP: begin
        // First RESP cycle commits; bvalid then holds until bready.
        if (!bvalid_q) begin
          reg_we   = wdec.mapped;
          bvalid_d = 1'b1;
          bresp_d  = wdec.mapped ? OKAY : SLVERR;
        end else if (bready) begin
          bvalid_d = 1'b0;
          wst_d    = WR_IDLE;
        end
      end
      default: wst_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rdst_d  = rdst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (rdst_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rdata_d = rdec.mapped ? rf_rdata : '0;
          rresp_d = rdec.mapped ? OKAY : SLVERR;
          rdst_d  = RD_RESP;
        end
      end
      RD_RESP: if (rready) rdst_d = RD_IDLE;
      default: rdst_d = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil_modport.sv
// Directed bench for axil_modport: a transaction-level model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_axil_modport;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_modport dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: what each bus output must be, advanced once per clock.
  logic [31:0] m_regs [16];
  bit          m_live, m_aw_have, m_w_have, m_commit, m_b_out, m_r_out;
  logic [15:0] m_awaddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  int          b_rise = 0;
  bit          prev_b = 1'b0;

  always @(negedge clk) begin : model
    bit aw_hs, w_hs, ar_hs;
    if (rst) begin
      chk("rst_ctrl_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      m_live = 0; m_aw_have = 0; m_w_have = 0; m_commit = 0; m_b_out = 0; m_r_out = 0;
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    end else begin
      chk("awready", awready, m_live && !m_aw_have);
      chk("wready", wready, m_live && !m_w_have);
      chk("arready", arready, m_live && !m_r_out);
      chk("bvalid", bvalid, m_b_out);
      if (m_b_out) chk("bresp", bresp, m_bresp);
      chk("rvalid", rvalid, m_r_out);
      if (m_r_out) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", rresp, m_rresp);
      end
      aw_hs = awvalid && m_live && !m_aw_have;
      w_hs  = wvalid && m_live && !m_w_have;
      ar_hs = arvalid && m_live && !m_r_out;
      // Read capture sees register contents before any commit on the same edge.
      if (m_r_out && rready) m_r_out = 0;
      else if (ar_hs) begin
        m_r_out  = 1;
        m_rdata  = (araddr < 16'h0040) ? m_regs[araddr[5:2]] : 32'd0;
        m_rresp  = (araddr < 16'h0040) ? 2'b00 : 2'b10;
      end
      if (m_b_out && bready) begin
        m_b_out = 0; m_aw_have = 0; m_w_have = 0;
      end else if (m_commit) begin
        if (m_awaddr < 16'h0040)
          for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) m_regs[m_awaddr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
        m_bresp  = (m_awaddr < 16'h0040) ? 2'b00 : 2'b10;
        m_b_out  = 1;
        m_commit = 0;
      end
      if (aw_hs) begin m_aw_have = 1; m_awaddr = awaddr; end
      if (w_hs)  begin m_w_have = 1; m_wdata = wdata; m_wstrb = wstrb; end
      if ((aw_hs || w_hs) && m_aw_have && m_w_have) m_commit = 1;
      m_live = 1;
    end
    if (bvalid && !prev_b) b_rise++;
    prev_b = bvalid;
  end

  // Drivers: all entered and left at 1ns after a rising edge.
  task automatic send_aw(input logic [15:0] a, input int dly);
    bit ok;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = awready; end
    @(posedge clk); #1; awvalid = 0;
    chk("aw_handshake_seen", ok, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = wready; end
    @(posedge clk); #1; wvalid = 0;
    chk("w_handshake_seen", ok, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold,
                          output logic [1:0] resp, output int lat);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (bvalid) break;
      lat++;
    end
    repeat (hold + 1) @(posedge clk);
    #1; bready = 1; resp = bresp;
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic do_read(input logic [15:0] a, input int dly, input int hold,
                         output logic [31:0] d, output logic [1:0] resp);
    bit ok;
    ok = 0;
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arvalid = 1;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = arready; end
    @(posedge clk); #1; arvalid = 0;
    chk("ar_handshake_seen", ok, 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = rvalid; end
    chk("rvalid_seen", ok, 1);
    repeat (hold + 1) @(posedge clk);
    #1; rready = 1; d = rdata; resp = rresp;
    @(posedge clk); #1; rready = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [1:0]  r, r2;
    logic [31:0] d;
    int          lat, nb;

    rst = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    chk("readies_after_release", {awready, wready, arready}, 3'b111);

    // Abort: write and read in flight, then reset while bvalid/rvalid are up.
    awaddr = 16'h0004; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 16'h0008; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(posedge clk); #2;
    chk("inflight_valids", {bvalid, rvalid}, 2'b11);
    rst = 1; #1;
    chk("abort_valids", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    chk("abort_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("readies_before_edge", {awready, wready, arready}, 3'b000);
    @(posedge clk); #1;
    chk("readies_after_edge", {awready, wready, arready}, 3'b111);

    do_read(16'h0008, 0, 0, d, r);
    chk("reset_read_0x8_data", d, 32'h0);
    chk("reset_read_0x8_resp", r, 2'b00);
    do_read(16'h0004, 0, 0, d, r);
    chk("aborted_write_cleared", d, 32'h0);

    // Plain write/read and byte strobes.
    do_write(16'h0004, 32'hDEADBEEF, 4'hF, 0, 0, 0, r, lat);
    chk("wr_0x4_bresp", r, 2'b00);
    chk("wr_commit_latency", lat, 1);
    do_read(16'h0004, 0, 0, d, r);
    chk("rd_0x4_data", d, 32'hDEADBEEF);
    chk("rd_0x4_resp", r, 2'b00);
    do_write(16'h0004, 32'h11223344, 4'h5, 0, 0, 0, r, lat);
    do_read(16'h0004, 0, 0, d, r);
    chk("strobe_merge", d, 32'hDE22BE44);
    do_read(16'h0007, 0, 0, d, r);
    chk("low_addr_bits_ignored", d, 32'hDE22BE44);

    // Channel ordering: W first, AW first, both together.
    nb = b_rise;
    do_write(16'h0000, 32'hA5A5A5A5, 4'hF, 3, 0, 0, r, lat);
    chk("w_first_bresp", r, 2'b00);
    chk("w_first_latency", lat, 1);
    do_write(16'h0008, 32'h12345678, 4'hF, 0, 3, 0, r, lat);
    chk("aw_first_bresp", r, 2'b00);
    chk("aw_first_latency", lat, 1);
    do_write(16'h003C, 32'hCAFEF00D, 4'hF, 0, 0, 0, r, lat);
    chk("same_cycle_bresp", r, 2'b00);
    chk("one_bvalid_per_write", b_rise - nb, 3);
    do_read(16'h003C, 0, 0, d, r);
    chk("rd_last_reg", d, 32'hCAFEF00D);
    do_read(16'h0000, 0, 0, d, r);
    chk("rd_w_first_reg", d, 32'hA5A5A5A5);

    // Backpressure on both paths at once.
    fork
      do_write(16'h0010, 32'h0BADF00D, 4'hF, 0, 0, 5, r2, lat);
      do_read(16'h0004, 0, 5, d, r);
    join
    chk("bp_bresp", r2, 2'b00);
    chk("bp_rdata", d, 32'hDE22BE44);
    do_read(16'h0010, 0, 0, d, r);
    chk("bp_write_landed", d, 32'h0BADF00D);

    // Read captured on the same edge as a write commit returns the old value.
    fork
      do_write(16'h0008, 32'h87654321, 4'hF, 0, 0, 0, r2, lat);
      do_read(16'h0008, 1, 0, d, r);
    join
    chk("same_edge_old_value", d, 32'h12345678);
    do_read(16'h0008, 0, 0, d, r);
    chk("later_read_new_value", d, 32'h87654321);

    // Unmapped addresses, including the first word past the map.
    do_write(16'h0100, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, lat);
    chk("unmapped_wr_bresp", r, 2'b10);
    do_write(16'h0040, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, lat);
    chk("edge_unmapped_wr_bresp", r, 2'b10);
    do_read(16'h0100, 0, 0, d, r);
    chk("unmapped_rd_data", d, 32'h0);
    chk("unmapped_rd_resp", r, 2'b10);
    do_read(16'h0040, 0, 0, d, r);
    chk("edge_unmapped_rd_resp", r, 2'b10);
    do_read(16'h0000, 0, 0, d, r);
    chk("reg0_untouched", d, 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
